// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine: one round per clock, 80 rounds plus one
// finalize cycle per 512-bit block, with the running hash chained across blocks.
module sha1_core #(
    parameter logic [159:0] IV = 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301
) (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         start,
    input  logic         first,
    input  logic [511:0] message,
    output logic         busy,
    output logic         done,
    output logic [6:0]   round_idx,
    output logic [159:0] digest
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_a, r_b, r_c, r_d, r_e;
    logic [15:0][31:0]  r_w;
    logic [6:0]         r_round;
    logic               r_done;
    logic [159:0]       r_digest;

    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic [31:0]        w_f;
    logic [31:0]        w_k;
    logic [31:0]        w_temp;
    logic [31:0]        w_mix;
    logic [31:0]        w_wnew;
    logic [159:0]       w_seed;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ROUND;
            S_ROUND: if (r_round == 7'd79) w_next = S_FINAL;
            S_FINAL: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE:  w_load = start;
            S_ROUND: w_step = 1'b1;
            S_FINAL: w_fin  = 1'b1;
            default: ;
        endcase
    end

    // Round function and constant, selected by the 20-round group
    always_comb begin
        if (r_round < 7'd20) begin
            w_f = (r_b & r_c) | (~r_b & r_d);
            w_k = 32'h5A827999;
        end else if (r_round < 7'd40) begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = 32'h6ED9EBA1;
        end else if (r_round < 7'd60) begin
            w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
            w_k = 32'h8F1BBCDC;
        end else begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = 32'hCA62C1D6;
        end
    end

    assign w_temp = {r_a[26:0], r_a[31:27]} + w_f + r_e + w_k + r_w[0];
    assign w_mix  = r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0];
    assign w_wnew = {w_mix[30:0], w_mix[31]};
    assign w_seed = first ? IV : r_digest;

    // Datapath: working variables, message window, counters and digest
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_e      <= '0;
            r_w      <= '0;
            r_round  <= '0;
            r_done   <= 1'b0;
            r_digest <= IV;
        end else if (w_load) begin
            r_w     <= message;
            r_a     <= w_seed[31:0];
            r_b     <= w_seed[63:32];
            r_c     <= w_seed[95:64];
            r_d     <= w_seed[127:96];
            r_e     <= w_seed[159:128];
            r_round <= '0;
            r_done  <= 1'b0;
            if (first) r_digest <= IV;
        end else if (w_step) begin
            r_a <= w_temp;
            r_b <= r_a;
            r_c <= {r_b[1:0], r_b[31:2]};
            r_d <= r_c;
            r_e <= r_d;
            r_w <= {w_wnew, r_w[15:1]};
            if (r_round != 7'd79) r_round <= r_round + 7'd1;
        end else if (w_fin) begin
            r_digest <= {r_digest[159:128] + r_e,
                         r_digest[127:96]  + r_d,
                         r_digest[95:64]   + r_c,
                         r_digest[63:32]   + r_b,
                         r_digest[31:0]    + r_a};
            r_done   <= 1'b1;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign round_idx = r_round;
    assign digest    = r_digest;

endmodule

// File: tb/tb_sha1_core.sv
// Scoreboarded bench for sha1_core: directed known-answer blocks plus random
// chained blocks checked against a full-schedule SHA-1 reference function.
module tb_sha1_core;

    localparam logic [159:0] IV     = 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301;
    localparam logic [159:0] D_NULL = 160'hAFD80709_95601890_3255BFEF_5E6B4B0D_DA39A3EE;
    localparam logic [159:0] D_ABC  = 160'h9CD0D89D_7850C26C_BA3E2571_4706816A_A9993E36;
    localparam logic [159:0] D_TWO  = 160'hE54670F1_F95129E5_BAAE4AA1_1C3BD26E_84983E44;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         first;
    logic [511:0] message;
    logic         busy;
    logic         done;
    logic [6:0]   round_idx;
    logic [159:0] digest;

    sha1_core dut (
        .wb_clk_i  (clk),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .message   (message),
        .busy      (busy),
        .done      (done),
        .round_idx (round_idx),
        .digest    (digest)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [159:0] dig;
        int unsigned  at;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         prev_done = 1'b0;
    logic [159:0] m_hash;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Straightforward SHA-1 compression with the full 80-word schedule
    function automatic logic [159:0] sha1_ref(input logic [159:0] h, input logic [511:0] m);
        logic [31:0] w[80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
        for (int i = 16; i < 80; i++) begin
            t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96]; e = h[159:128];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + e, h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every rising done pops one expectation (digest and cycle)
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual digest %h required no completion", digest);
            end else begin
                mon_e = sb.pop_front();
                chk("digest", digest, mon_e.dig);
                chk("done_cycle", 160'(cyc), 160'(mon_e.at));
            end
        end
        prev_done <= done;
    end

    // Present a block for one cycle; returns just after the accepting edge
    task automatic issue(input logic f, input logic [511:0] m, input logic [159:0] exp_dig);
        exp_t x;
        start   = 1'b1;
        first   = f;
        message = m;
        x.dig   = exp_dig;
        x.at    = cyc + 82;
        sb.push_back(x);
        @(negedge clk);
        start   = 1'b0;
        first   = 1'($urandom);
        message = rand512();
        chk("done_low_on_accept", 160'(done), 160'(0));
        chk("busy_on_accept", 160'(busy), 160'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done && !busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: actual done=%0b busy=%0b required done=1 within 200 cycles", done, busy);
        end
    endtask

    task automatic chk_idle_reset();
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_done", 160'(done), 160'(0));
        chk("rst_round_idx", 160'(round_idx), 160'(0));
        chk("rst_digest", digest, IV);
    endtask

    logic [511:0] msg_null, msg_abc, msg_b1, msg_b2, rmsg;
    logic [31:0]  b1w[16];
    logic         rf;
    int           bad;
    int           n;

    initial begin
        b1w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        msg_null = '0; msg_null[31:0] = 32'h80000000;
        msg_abc  = '0; msg_abc[31:0]  = 32'h61626380; msg_abc[511:480] = 32'h00000018;
        msg_b2   = '0; msg_b2[511:480] = 32'h000001C0;
        for (int i = 0; i < 16; i++) msg_b1[32*i +: 32] = b1w[i];

        reset = 1'b1; start = 1'b0; first = 1'b0; message = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle_reset();

        // Empty string
        issue(1'b1, msg_null, D_NULL);
        wait_done();

        // "abc" with round-by-round progress and an ignored start at round 40
        issue(1'b1, msg_abc, D_ABC);
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            if (round_idx !== 7'(k) || busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == 40) begin
                start = 1'b1; first = 1'b1; message = rand512();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("round_progress_errors", 160'(bad), 160'(0));
        chk("final_round_idx", 160'(round_idx), 160'(79));
        chk("final_busy", 160'(busy), 160'(1));
        wait_done();
        chk("hold_round_idx", 160'(round_idx), 160'(79));

        // Re-start from done with the same block
        issue(1'b1, msg_abc, D_ABC);
        wait_done();

        // Two-block chaining
        m_hash = sha1_ref(IV, msg_b1);
        issue(1'b1, msg_b1, m_hash);
        wait_done();
        issue(1'b0, msg_b2, D_TWO);
        wait_done();

        // Reset at round 50 discards the block
        issue(1'b1, msg_abc, D_ABC);
        n = 0;
        while (round_idx != 7'd50 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round_50", 160'(round_idx), 160'(50));
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk_idle_reset();
        issue(1'b1, msg_abc, D_ABC);
        wait_done();
        m_hash = D_ABC;

        // Random chained blocks, mostly back-to-back, sometimes with idle gaps
        for (int i = 0; i < 12; i++) begin
            rf     = (i == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            rmsg   = rand512();
            m_hash = sha1_ref(rf ? IV : m_hash, rmsg);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            issue(rf, rmsg, m_hash);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 160'(sb.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha1_core.md
Name: sha1_core

Overview:
- Iterative SHA-1 compression engine that sits directly downstream of the Wishbone register front-end.
- Consumes the 512-bit message block assembled by the front-end and produces the 160-bit digest the front-end returns to software.
- Performs one round per clock: 80 rounds plus 1 finalize cycle per block.
- Supports multi-block messages by chaining the running hash across blocks.

Parameters:
- IV, 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301: initial hash, packed H0 in [31:0] up to H4 in [159:128].

Ports:
- wb_clk_i  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to compress `message`; sampled only when idle.
- first  input  1  sampled with start. 1 = initialise the hash from IV; 0 = continue from the current digest register.
- message  input  512  block data. W[i] = message[32i+31:32i], i = 0..15; W[0] is the first big-endian word of the block.
- busy  output  1  high while rounds or finalize are in progress.
- done  output  1  level; high when digest is valid, until the next accepted start.
- round_idx  output  7  current round 0..79; holds 79 after completion; 0 in idle after reset.
- digest  output  160  running hash, H0 in [31:0] ... H4 in [159:128]; valid when done=1.

Behaviour:
- Reset: busy=0, done=0, round_idx=0, digest=IV, a..e=0, W window=0, state=IDLE. Reset overrides every other input on the same edge, including mid-block; the in-flight block is discarded.
- States are IDLE, ROUND and FINAL.
- IDLE:
  - Transition: on start=1 at edge N, go to ROUND.
  - Load W window[0..15] from message.
  - If first=1, load digest<=IV and a..e<=IV words; if first=0, load a..e<=current digest words.
  - Set round_idx<=0, busy<=1, done<=0.
- ROUND: each edge executes round t=round_idx.
  - Rounds 0..19: f = (b&c)|(~b&d), K=5A827999.
  - Rounds 20..39: f = b^c^d, K=6ED9EBA1.
  - Rounds 40..59: f = (b&c)|(b&d)|(c&d), K=8F1BBCDC.
  - Rounds 60..79: f = b^c^d, K=CA62C1D6.
  - Register updates: temp = rol5(a)+f+e+K+W[t], all sums mod 2^32. Then e<=d, d<=c, c<=rol30(b), b<=a, a<=temp.
  - Schedule: 16-entry shift window; the word consumed is window[0]. Each round shifts in rol1(window[13]^window[8]^window[2]^window[0]).
  - round_idx increments each edge. Round 79 is executed at edge N+80; round_idx stays 79 and the state goes to FINAL.
- FINAL (edge N+81): digest Hk <= Hk + (a,b,c,d,e)k mod 2^32, done<=1, busy<=0, state -> IDLE.
- Latency: start sampled at edge N gives done=1 and a valid digest after edge N+81 (82 cycles).
- start while busy=1 is ignored: no effect, no queuing.
- start while done=1 is accepted: done drops on the accepting edge.
- first is ignored unless start is accepted.
- message is captured on the accepting edge only; later changes have no effect on the block in progress.
- digest is stable outside FINAL; it changes only at reset, on acceptance with first=1 (to IV), and in FINAL.
- Back-to-back blocks: start may be asserted in the cycle after done rises. No dead cycles are required beyond the 82-cycle block latency.
- No combinational path from inputs to outputs.

Test Plan:
- Empty string: reset, start with first=1, message W0=80000000, W1..W15=0 -> exactly 82 cycles after the start edge, done=1 and digest H0..H4 = DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709.
- "abc": first=1, W0=61626380, W1..W14=0, W15=00000018 -> digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D. round_idx steps 0..79 with busy=1 throughout the rounds.
- Two-block chaining: block 1 with first=1, words 61626364 62636465 63646566 64656667 65666768 66676869 6768696A 68696A6B 696A6B6C 6A6B6C6D 6B6C6D6E 6C6D6E6F 6D6E6F70 6E6F7071 80000000 00000000. Then block 2 with first=0: W0..W14=0, W15=000001C0 -> final digest 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1.
- Ignored start: during block 1 of the "abc" case, pulse start at round 40 with first=1 and a different message -> result is unchanged and done still rises at cycle 82.
- Reset mid-operation: assert reset at round 50 of a block -> next cycle busy=0, done=0, round_idx=0, digest=IV. A following "abc" run then yields the correct digest.
- Re-start from done: after the "abc" result, start "abc" again with first=1 -> done drops on the accepting edge and the same digest reappears 82 cycles later.
